// File: rtl/t07_spi_esp32.sv
// rtl/t07_spi_esp32.sv - quad-wide serial frame receiver from the ESP32 co-processor
// Optional feature macro: T07_SPI_ESP32_VALID_STROBE_EN (adds one-cycle dataValid strobe)
module t07_spi_esp32 #(
  parameter int         SCLK_HALF   = 1,
  parameter logic [3:0] SYNC_NIBBLE = 4'hA
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [3:0]  ESP_in,
  output logic [5:0]  SPI_Address,
  output logic [31:0] dataForExtReg,
`ifdef T07_SPI_ESP32_VALID_STROBE_EN
  output logic        dataValid,
`endif
  output logic        SCLK_out
);

  localparam int CNT_W = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCLK_HALF - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [CNT_W-1:0]  div_cnt;
  logic              div_wrap;
  logic              sample;
  logic [2:0]        nib_cnt;
  logic [2:0]        nib_cnt_next;
  logic              addr_en;
  logic              data_en;
  logic              commit;
  // Only the low 6 address bits survive; the top two fall off the shifter.
  logic [5:0]        addr_sh;
  // Seven data nibbles are held here; the eighth is appended at commit.
  logic [27:0]       data_sh;

  assign div_wrap = (div_cnt == CNT_LAST);
  // Sample on the edge that drives SCLK_out from 0 to 1.
  assign sample   = div_wrap && !SCLK_out;

  // Free-running SCLK divider, never gated by the FSM.
  always_ff @(posedge clk) begin
    if (nrst) begin
      div_cnt  <= '0;
      SCLK_out <= 1'b0;
    end else if (div_wrap) begin
      div_cnt  <= '0;
      SCLK_out <= !SCLK_out;
    end else begin
      div_cnt  <= div_cnt + 1'b1;
    end
  end

  // Frame state and nibble counter registers.
  always_ff @(posedge clk) begin
    if (nrst) begin
      state   <= IDLE;
      nib_cnt <= 3'd0;
    end else begin
      state   <= state_next;
      nib_cnt <= nib_cnt_next;
    end
  end

  // Next-state and datapath controls; payload nibbles equal to SYNC are plain data.
  always_comb begin
    state_next   = state;
    nib_cnt_next = nib_cnt;
    addr_en      = 1'b0;
    data_en      = 1'b0;
    commit       = 1'b0;
    if (sample) begin
      case (state)
        IDLE: begin
          if (ESP_in == SYNC_NIBBLE) begin
            state_next   = ADDR;
            nib_cnt_next = 3'd0;
          end
        end
        ADDR: begin
          addr_en = 1'b1;
          if (nib_cnt == 3'd1) begin
            state_next   = DATA;
            nib_cnt_next = 3'd0;
          end else begin
            nib_cnt_next = nib_cnt + 3'd1;
          end
        end
        DATA: begin
          if (nib_cnt == 3'd7) begin
            commit       = 1'b1;
            state_next   = IDLE;
            nib_cnt_next = 3'd0;
          end else begin
            data_en      = 1'b1;
            nib_cnt_next = nib_cnt + 3'd1;
          end
        end
        default: begin
          state_next   = IDLE;
          nib_cnt_next = 3'd0;
        end
      endcase
    end
  end

  // Address and data shift registers, MSB nibble first.
  always_ff @(posedge clk) begin
    if (nrst) begin
      addr_sh <= '0;
      data_sh <= '0;
    end else begin
      if (addr_en) addr_sh <= {addr_sh[1:0], ESP_in};
      if (data_en) data_sh <= {data_sh[23:0], ESP_in};
    end
  end

  // Output registers: updated only at commit, held otherwise.
  always_ff @(posedge clk) begin
    if (nrst) begin
      SPI_Address   <= '0;
      dataForExtReg <= '0;
    end else if (commit) begin
      SPI_Address   <= addr_sh;
      dataForExtReg <= {data_sh, ESP_in};
    end
  end

`ifdef T07_SPI_ESP32_VALID_STROBE_EN
  // One-cycle strobe aligned with the first cycle of new output values.
  always_ff @(posedge clk) begin
    if (nrst) dataValid <= 1'b0;
    else      dataValid <= commit;
  end
`endif

endmodule

// File: tb/tb_t07_spi_esp32.sv
// tb/tb_t07_spi_esp32.sv - scoreboard testbench for t07_spi_esp32
module tb_t07_spi_esp32;

  logic        clk;
  logic        nrst;
  logic [3:0]  esp_in;
  logic [5:0]  spi_address;
  logic [31:0] data_ext;
  logic        sclk;
`ifdef T07_SPI_ESP32_VALID_STROBE_EN
  logic        data_valid;
`endif

  int tests;
  int fails;
  logic [37:0] exp_q[$];
  logic [37:0] prev_out;

  t07_spi_esp32 #(.SCLK_HALF(1), .SYNC_NIBBLE(4'hA)) dut (
    .clk           (clk),
    .nrst          (nrst),
    .ESP_in        (esp_in),
    .SPI_Address   (spi_address),
    .dataForExtReg (data_ext),
`ifdef T07_SPI_ESP32_VALID_STROBE_EN
    .dataValid     (data_valid),
`endif
    .SCLK_out      (sclk)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: whenever the outputs change, pop and compare the expected frame.
  always @(posedge clk) begin
    logic [37:0] cur;
    logic [37:0] exp_v;
    logic        chg;
    #1;
    if (nrst) begin
      prev_out = '0;
    end else begin
      cur = {spi_address, data_ext};
      chg = (cur !== prev_out);
`ifdef T07_SPI_ESP32_VALID_STROBE_EN
      tests++;
      if (data_valid !== chg) begin
        fails++;
        $display("FAIL valid_strobe: dataValid=%b, required %b", data_valid, chg);
      end
`endif
      if (chg) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_update: addr=%h data=%h, required no change", spi_address, data_ext);
        end else begin
          exp_v = exp_q.pop_front();
          if (cur !== exp_v) begin
            fails++;
            $display("FAIL frame_out: addr=%h data=%h, required addr=%h data=%h",
                     spi_address, data_ext, exp_v[37:32], exp_v[31:0]);
          end
        end
        prev_out = cur;
      end
    end
  end

  task automatic check(input string name, input logic [37:0] act, input logic [37:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Drive the next nibble right after SCLK_out falls, bounded wait.
  task automatic send_nib(input logic [3:0] n);
    logic p;
    bit   found;
    p = sclk;
    found = 1'b0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (p == 1'b1 && sclk == 1'b0) begin
        found = 1'b1;
        break;
      end
      p = sclk;
    end
    if (!found) begin
      tests++;
      fails++;
      $display("FAIL sclk_timeout: no SCLK fall seen, required one within 64 clk");
    end
    esp_in = n;
  endtask

  task automatic send_frame(input logic [43:0] f);
    for (int i = 10; i >= 0; i--) send_nib(f[i*4 +: 4]);
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 100; k++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s: %0d frames pending, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    logic p;
    tests = 0;
    fails = 0;
    prev_out = '0;
    nrst = 1'b1;
    esp_in = 4'hF;
    repeat (2) @(negedge clk);
    check("reset_sclk", {37'd0, sclk}, 38'd0);
    check("reset_outputs", {spi_address, data_ext}, 38'd0);
    nrst = 1'b0;

    p = sclk;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("sclk_toggle", {37'd0, sclk}, {37'd0, ~p});
      p = sclk;
    end

    send_frame(44'hA15DEADBEEF);
    exp_q.push_back({6'h15, 32'hDEADBEEF});
    drain("basic_frame");
    for (int i = 0; i < 10; i++) send_nib(4'h0);
    check("hold_basic", {spi_address, data_ext}, {6'h15, 32'hDEADBEEF});

    send_frame(44'hAFFAAAAAAAA);
    exp_q.push_back({6'h3F, 32'hAAAAAAAA});
    drain("trunc_frame");

    send_nib(4'hB);
    send_nib(4'hC);
    send_nib(4'h0);
    send_frame(44'hA0112345678);
    exp_q.push_back({6'h01, 32'h12345678});
    send_frame(44'hA20C0FFEE00);
    exp_q.push_back({6'h20, 32'hC0FFEE00});
    drain("back_to_back");
    for (int i = 0; i < 4; i++) send_nib(4'h0);
    check("hold_b2b", {spi_address, data_ext}, {6'h20, 32'hC0FFEE00});

    send_nib(4'hA);
    send_nib(4'h1);
    send_nib(4'h5);
    send_nib(4'hD);
    @(negedge clk);
    nrst = 1'b1;
    esp_in = 4'h0;
    repeat (2) @(negedge clk);
    check("midreset_outputs", {spi_address, data_ext}, 38'd0);
    check("midreset_sclk", {37'd0, sclk}, 38'd0);
    nrst = 1'b0;
    send_frame(44'hA0300000001);
    exp_q.push_back({6'h03, 32'h00000001});
    drain("post_reset_frame");
    for (int i = 0; i < 4; i++) send_nib(4'h0);
    check("hold_final", {spi_address, data_ext}, {6'h03, 32'h00000001});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
